// File: rtl/ps2_host_cmd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_host_cmd_ctrl_if                                            |
// | Purpose  : Bundles the command, PS/2 transmit, PS/2 receive, scan-forward  |
// |            and response signals of ps2_host_cmd_ctrl.                      |
// | Modports : slave  - the command controller itself                          |
// |            master - the system / tx engine / rx engine side driving it     |
// | Signals  : cmd_valid/cmd_ready/cmd_byte/cmd_has_arg/cmd_arg  command req   |
// |            tx_valid/tx_ready/tx_data/tx_done/tx_err           PS/2 tx      |
// |            rx_valid/rx_data                                   PS/2 rx      |
// |            scan_valid/scan_data                               forwarded rx |
// |            resp_valid/resp_ok/resp_code/busy                  completion   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface ps2_host_cmd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_byte;
  logic       cmd_has_arg;
  logic [7:0] cmd_arg;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       scan_valid;
  logic [7:0] scan_data;
  logic       resp_valid;
  logic       resp_ok;
  logic [7:0] resp_code;
  logic       busy;

  modport slave (
    input  cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
    input  tx_ready, tx_done, tx_err,
    input  rx_valid, rx_data,
    output cmd_ready, tx_valid, tx_data,
    output scan_valid, scan_data,
    output resp_valid, resp_ok, resp_code, busy
  );

  modport master (
    output cmd_valid, cmd_byte, cmd_has_arg, cmd_arg,
    output tx_ready, tx_done, tx_err,
    output rx_valid, rx_data,
    input  cmd_ready, tx_valid, tx_data,
    input  scan_valid, scan_data,
    input  resp_valid, resp_ok, resp_code, busy
  );
endinterface
`default_nettype wire

// File: rtl/ps2_host_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_host_cmd_ctrl                                               |
// | Purpose  : Host-side PS/2 keyboard command sequencer. Sends a command byte |
// |            and optional argument byte through the tx engine, waits for the |
// |            device ACK (0xFA), resends on NAK (0xFE) or tx error, applies a |
// |            timeout, and forwards all non-handshake rx bytes as scan codes. |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            bus : ps2_host_cmd_ctrl_if.slave (command / tx / rx / scan /    |
// |                  response groups, see the interface file)                  |
// | Params   : TIMEOUT_CYCLES - cycles to wait for an ACK or BAT byte          |
// |            MAX_RETRIES    - resends per byte after the first send          |
// | Macro    : PS2_BAT_WAIT_EN - an ACKed 0xFF also waits for the BAT result   |
// |            (0xAA ok, 0xFC fail) before finishing.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_host_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 320000,
  parameter int MAX_RETRIES    = 3
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  ps2_host_cmd_ctrl_if.slave bus
);

  localparam int c_tmr_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_rty_w = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [c_tmr_w-1:0] c_TO_LAST   = c_tmr_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_rty_w-1:0] c_MAX_RETRY = c_rty_w'(MAX_RETRIES);

  localparam logic [7:0] c_RX_ACK      = 8'hFA;
  localparam logic [7:0] c_RX_NAK      = 8'hFE;
  localparam logic [7:0] c_RC_OK       = 8'h00;
  localparam logic [7:0] c_RC_TIMEOUT  = 8'h01;
  localparam logic [7:0] c_RC_RETRIES  = 8'h02;
`ifdef PS2_BAT_WAIT_EN
  localparam logic [7:0] c_RX_BAT_OK   = 8'hAA;
  localparam logic [7:0] c_RX_BAT_FAIL = 8'hFC;
  localparam logic [7:0] c_RC_BAT_FAIL = 8'h03;
  localparam logic [7:0] c_CMD_RESET   = 8'hFF;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_TX  = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_FINISH   = 3'd5
`ifdef PS2_BAT_WAIT_EN
    ,S_WAIT_BAT = 3'd4
`endif
  } state_t;

  state_t               r_state;
  logic [7:0]           r_cmd;
  logic                 r_has_arg;
  logic [7:0]           r_arg;
  logic                 r_on_arg;     // 1 once the command byte is ACKed
  logic [c_rty_w-1:0]   r_retry;
  logic [c_tmr_w-1:0]   r_timer;
  logic                 r_tx_valid;
  logic [7:0]           r_tx_data;
  logic                 r_scan_valid;
  logic [7:0]           r_scan_data;
  logic                 r_resp_valid;
  logic                 r_resp_ok;
  logic [7:0]           r_resp_code;
  logic                 r_busy;

  logic                 w_rx_ack;
  logic                 w_rx_nak;
  logic                 w_timeout;
  logic                 w_can_retry;
  logic [7:0]           w_cur_byte;
  logic                 w_consume;

  assign w_rx_ack    = bus.rx_valid && (bus.rx_data == c_RX_ACK);
  assign w_rx_nak    = bus.rx_valid && (bus.rx_data == c_RX_NAK);
  assign w_timeout   = (r_timer == c_TO_LAST);
  assign w_can_retry = (r_retry < c_MAX_RETRY);
  assign w_cur_byte  = r_on_arg ? r_arg : r_cmd;

  // Handshake bytes are swallowed only in the state that is waiting for
  // them; everywhere else (IDLE, SEND, WAIT_TX, FINISH) they are plain data.
  always_comb begin
    w_consume = 1'b0;
    if (bus.rx_valid) begin
      case (r_state)
        S_WAIT_ACK: w_consume = (bus.rx_data == c_RX_ACK) || (bus.rx_data == c_RX_NAK);
`ifdef PS2_BAT_WAIT_EN
        S_WAIT_BAT: w_consume = (bus.rx_data == c_RX_BAT_OK) || (bus.rx_data == c_RX_BAT_FAIL);
`endif
        default:    w_consume = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmd        <= 8'h00;
      r_has_arg    <= 1'b0;
      r_arg        <= 8'h00;
      r_on_arg     <= 1'b0;
      r_retry      <= '0;
      r_timer      <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_scan_valid <= 1'b0;
      r_scan_data  <= 8'h00;
      r_resp_valid <= 1'b0;
      r_resp_ok    <= 1'b0;
      r_resp_code  <= 8'h00;
      r_busy       <= 1'b0;
    end else begin
      // Scan forwarding runs alongside the sequencer in every state.
      r_scan_valid <= bus.rx_valid && !w_consume;
      if (bus.rx_valid && !w_consume) begin
        r_scan_data <= bus.rx_data;
      end

      r_resp_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_cmd      <= bus.cmd_byte;
            r_has_arg  <= bus.cmd_has_arg;
            r_arg      <= bus.cmd_arg;
            r_on_arg   <= 1'b0;
            r_retry    <= '0;
            r_busy     <= 1'b1;
            r_tx_valid <= 1'b1;
            r_tx_data  <= bus.cmd_byte;
            r_state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_WAIT_TX;
          end
        end

        S_WAIT_TX: begin
          // tx_err is checked first so it wins over a coincident tx_done.
          if (bus.tx_err) begin
            if (w_can_retry) begin
              r_retry    <= r_retry + c_rty_w'(1);
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_cur_byte;
              r_state    <= S_SEND;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_ok    <= 1'b0;
              r_resp_code  <= c_RC_RETRIES;
              r_state      <= S_FINISH;
            end
          end else if (bus.tx_done) begin
            r_timer <= '0;
            r_state <= S_WAIT_ACK;
          end
        end

        S_WAIT_ACK: begin
          r_timer <= r_timer + c_tmr_w'(1);
          // ACK is tested before the timeout so it wins a same-cycle tie.
          if (w_rx_ack) begin
            if (!r_on_arg && r_has_arg) begin
              r_on_arg   <= 1'b1;
              r_retry    <= '0;
              r_tx_valid <= 1'b1;
              r_tx_data  <= r_arg;
              r_state    <= S_SEND;
            end
`ifdef PS2_BAT_WAIT_EN
            else if (r_cmd == c_CMD_RESET) begin
              r_timer <= '0;
              r_state <= S_WAIT_BAT;
            end
`endif
            else begin
              r_resp_valid <= 1'b1;
              r_resp_ok    <= 1'b1;
              r_resp_code  <= c_RC_OK;
              r_state      <= S_FINISH;
            end
          end else if (w_rx_nak) begin
            if (w_can_retry) begin
              r_retry    <= r_retry + c_rty_w'(1);
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_cur_byte;
              r_state    <= S_SEND;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_ok    <= 1'b0;
              r_resp_code  <= c_RC_RETRIES;
              r_state      <= S_FINISH;
            end
          end else if (w_timeout) begin
            r_resp_valid <= 1'b1;
            r_resp_ok    <= 1'b0;
            r_resp_code  <= c_RC_TIMEOUT;
            r_state      <= S_FINISH;
          end
        end

`ifdef PS2_BAT_WAIT_EN
        S_WAIT_BAT: begin
          r_timer <= r_timer + c_tmr_w'(1);
          if (bus.rx_valid && (bus.rx_data == c_RX_BAT_OK)) begin
            r_resp_valid <= 1'b1;
            r_resp_ok    <= 1'b1;
            r_resp_code  <= c_RC_OK;
            r_state      <= S_FINISH;
          end else if (bus.rx_valid && (bus.rx_data == c_RX_BAT_FAIL)) begin
            r_resp_valid <= 1'b1;
            r_resp_ok    <= 1'b0;
            r_resp_code  <= c_RC_BAT_FAIL;
            r_state      <= S_FINISH;
          end else if (w_timeout) begin
            r_resp_valid <= 1'b1;
            r_resp_ok    <= 1'b0;
            r_resp_code  <= c_RC_TIMEOUT;
            r_state      <= S_FINISH;
          end
        end
`endif

        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.scan_valid = r_scan_valid;
  assign bus.scan_data  = r_scan_data;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_ok    = r_resp_ok;
  assign bus.resp_code  = r_resp_code;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ps2_host_cmd_ctrl                                            |
// | Purpose  : Self-checking bench for ps2_host_cmd_ctrl. A scripted device    |
// |            answers each transmitted byte with ACK / NAK / tx error /       |
// |            silence; expected tx sequence and result code come from a       |
// |            per-byte attempt model, scan bytes from an expected queue.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ps2_host_cmd_ctrl;
  localparam int TO = 64;
  localparam int MR = 3;
  localparam int OC_ACK = 0;
  localparam int OC_NAK = 1;
  localparam int OC_ERR = 2;
  localparam int OC_SIL = 3;

  typedef struct {
    logic [7:0] d;
    int         c;
  } scan_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  int         resp_cnt = 0;
  int         resp_cyc = 0;
  logic       resp_ok_q = 1'b0;
  logic [7:0] resp_code_q = 8'h00;
  logic [7:0] tx_seen[$];
  scan_t      scan_exp[$];
  int         oc[8];

  ps2_host_cmd_ctrl_if u_if();

  ps2_host_cmd_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES   (MR)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor, sampled mid-cycle.
  initial begin
    scan_t s;
    forever begin
      @(negedge clk);
      if (u_if.tx_valid && u_if.tx_ready) tx_seen.push_back(u_if.tx_data);
      if (u_if.resp_valid) begin
        resp_cnt++;
        resp_cyc    = cyc;
        resp_ok_q   = u_if.resp_ok;
        resp_code_q = u_if.resp_code;
      end
      if (u_if.scan_valid) begin
        chk("scan_expected", 32'(scan_exp.size() != 0), 32'd1);
        if (scan_exp.size() != 0) begin
          s = scan_exp.pop_front();
          chk("scan_data", 32'(u_if.scan_data), 32'(s.d));
          chk("scan_latency", 32'(cyc), 32'(s.c));
        end
      end
    end
  end

  function automatic logic [7:0] rand_scan();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hFA || b == 8'hFE) b = 8'h1C;
    return b;
  endfunction

  task automatic rx_byte(input logic [7:0] b, input bit fwd);
    u_if.rx_valid = 1'b1;
    u_if.rx_data  = b;
    if (fwd) scan_exp.push_back('{b, cyc + 1});
    tick();
    u_if.rx_valid = 1'b0;
  endtask

  task automatic wait_hs_or_resp(output int r);
    int c0;
    bit hs;
    c0 = resp_cnt;
    r  = -1;
    for (int i = 0; i < 300; i++) begin
      u_if.tx_ready = ($urandom_range(0, 2) != 0);
      hs = u_if.tx_valid && u_if.tx_ready;
      tick();
      u_if.tx_ready = 1'b0;
      if (hs) begin r = 1; return; end
      if (resp_cnt != c0) begin r = 0; return; end
    end
  endtask

  task automatic wait_resp(input int c0);
    for (int i = 0; i < 300 && resp_cnt == c0; i++) tick();
    chk("resp_count", 32'(resp_cnt - c0), 32'd1);
  endtask

  task automatic issue(input logic [7:0] c, input bit ha, input logic [7:0] a);
    logic [7:0] hsb[4];
    hsb = '{8'hFA, 8'hFE, 8'hAA, 8'hFC};
    for (int i = 0; i < 200 && !u_if.cmd_ready; i++) tick();
    chk("cmd_ready_idle", 32'(u_if.cmd_ready), 32'd1);
    u_if.cmd_valid   = 1'b1;
    u_if.cmd_byte    = c;
    u_if.cmd_has_arg = ha;
    u_if.cmd_arg     = a;
    if ($urandom_range(0, 1) == 1) begin
      u_if.rx_valid = 1'b1;
      u_if.rx_data  = ($urandom_range(0, 1) == 1) ? hsb[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
      scan_exp.push_back('{u_if.rx_data, cyc + 1});
    end
    tick();
    u_if.cmd_valid   = 1'b0;
    u_if.rx_valid    = 1'b0;
    u_if.cmd_byte    = 8'($urandom_range(0, 255));
    u_if.cmd_arg     = 8'($urandom_range(0, 255));
    u_if.cmd_has_arg = 1'($urandom_range(0, 1));
    chk("busy_on_accept", 32'(u_if.busy), 32'd1);
    chk("cmd_ready_busy", 32'(u_if.cmd_ready), 32'd0);
  endtask

  // Runs one command; the device answers the n-th transmitted byte with oc[n].
  task automatic run_cmd(input logic [7:0] c, input bit ha, input logic [7:0] a);
    logic [7:0] exp_tx[$];
    int exp_code, k, r, idx, o, c0, done_cyc;
    bit ended, acked, silent_end;

    // Reference: each byte gets up to MR+1 attempts; silence ends the command.
    k = 0; exp_code = 0; ended = 0;
    for (int b = 0; b < (ha ? 2 : 1) && !ended; b++) begin
      acked = 0;
      for (int t = 0; t <= MR && !acked && !ended; t++) begin
        exp_tx.push_back(b == 0 ? c : a);
        o = oc[k];
        k++;
        if (o == OC_ACK) acked = 1;
        else if (o == OC_SIL) begin exp_code = 1; ended = 1; end
      end
      if (!acked && !ended) begin exp_code = 2; ended = 1; end
    end

    tx_seen.delete();
    c0 = resp_cnt; idx = 0; done_cyc = 0; silent_end = 0;
    issue(c, ha, a);
    for (int g = 0; g < 12; g++) begin
      wait_hs_or_resp(r);
      if (r != 1) break;
      o = (idx < 8) ? oc[idx] : OC_ACK;
      idx++;
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 3) == 0) rx_byte(8'($urandom_range(0, 255)), 1'b1);
      if (o == OC_ERR) begin
        u_if.tx_err  = 1'b1;
        u_if.tx_done = 1'($urandom_range(0, 1));
        tick();
        u_if.tx_err  = 1'b0;
        u_if.tx_done = 1'b0;
      end else begin
        u_if.tx_done = 1'b1;
        done_cyc = cyc;
        tick();
        u_if.tx_done = 1'b0;
        if (o == OC_SIL) begin
          silent_end = 1;
          rx_byte(8'h1C, 1'b1);
          rx_byte(8'hF0, 1'b1);
        end else begin
          if ($urandom_range(0, 1) == 1) rx_byte(rand_scan(), 1'b1);
          rx_byte((o == OC_ACK) ? 8'hFA : 8'hFE, 1'b0);
        end
      end
    end

    chk("resp_count", 32'(resp_cnt - c0), 32'd1);
    chk("resp_ok", 32'(resp_ok_q), 32'(exp_code == 0));
    chk("resp_code", 32'(resp_code_q), 32'(exp_code));
    chk("tx_count", 32'(tx_seen.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_seen.size(); i++)
      chk("tx_byte", 32'(tx_seen[i]), 32'(exp_tx[i]));
    // tx_done driven in cycle d is sampled at edge d+1; expiry TO edges later.
    if (silent_end) chk("timeout_latency", 32'(resp_cyc - done_cyc), 32'(TO + 1));
    chk("busy_after", 32'(u_if.busy), 32'd0);
    chk("ready_after", 32'(u_if.cmd_ready), 32'd1);
  endtask

  initial begin
    int r, c0;
    u_if.cmd_valid = 1'b0; u_if.cmd_byte = 8'h00; u_if.cmd_has_arg = 1'b0; u_if.cmd_arg = 8'h00;
    u_if.tx_ready = 1'b0; u_if.tx_done = 1'b0; u_if.tx_err = 1'b0;
    u_if.rx_valid = 1'b0; u_if.rx_data = 8'h00;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_tx_valid", 32'(u_if.tx_valid), 32'd0);
    chk("rst_tx_data", 32'(u_if.tx_data), 32'd0);
    chk("rst_scan_valid", 32'(u_if.scan_valid), 32'd0);
    chk("rst_scan_data", 32'(u_if.scan_data), 32'd0);
    chk("rst_resp_valid", 32'(u_if.resp_valid), 32'd0);
    chk("rst_resp_ok", 32'(u_if.resp_ok), 32'd0);
    chk("rst_resp_code", 32'(u_if.resp_code), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) tick();

    oc = '{OC_ACK, 0, 0, 0, 0, 0, 0, 0};
    run_cmd(8'hF4, 1'b0, 8'h00);
    oc = '{OC_ACK, OC_ACK, 0, 0, 0, 0, 0, 0};
    run_cmd(8'hED, 1'b1, 8'h02);
    oc = '{OC_NAK, OC_NAK, OC_NAK, OC_ACK, OC_ACK, 0, 0, 0};
    run_cmd(8'hED, 1'b1, 8'h04);
    oc = '{OC_NAK, OC_NAK, OC_NAK, OC_NAK, OC_ACK, 0, 0, 0};
    run_cmd(8'hED, 1'b1, 8'h07);
    oc = '{OC_SIL, 0, 0, 0, 0, 0, 0, 0};
    run_cmd(8'hF4, 1'b0, 8'h00);
    oc = '{OC_ERR, OC_NAK, OC_ACK, OC_ERR, OC_ERR, OC_ERR, OC_ERR, 0};
    run_cmd(8'hF3, 1'b1, 8'h20);
    oc = '{OC_ACK, OC_NAK, OC_SIL, 0, 0, 0, 0, 0};
    run_cmd(8'hF0, 1'b1, 8'h02);

    // 0xFF reset command: with the BAT wait the ACK alone does not finish it.
    tx_seen.delete();
    c0 = resp_cnt;
    issue(8'hFF, 1'b0, 8'h00);
    wait_hs_or_resp(r);
    u_if.tx_done = 1'b1; tick(); u_if.tx_done = 1'b0;
    rx_byte(8'hFA, 1'b0);
`ifdef PS2_BAT_WAIT_EN
    repeat (4) tick();
    chk("bat_no_early_resp", 32'(resp_cnt - c0), 32'd0);
    rx_byte(8'h55, 1'b1);
    rx_byte(8'hAA, 1'b0);
    wait_resp(c0);
    chk("bat_ok", 32'(resp_ok_q), 32'd1);
    chk("bat_code", 32'(resp_code_q), 32'h00);
    c0 = resp_cnt;
    issue(8'hFF, 1'b0, 8'h00);
    wait_hs_or_resp(r);
    u_if.tx_done = 1'b1; tick(); u_if.tx_done = 1'b0;
    rx_byte(8'hFA, 1'b0);
    rx_byte(8'hFC, 1'b0);
    wait_resp(c0);
    chk("bat_fail_ok", 32'(resp_ok_q), 32'd0);
    chk("bat_fail_code", 32'(resp_code_q), 32'h03);
`else
    wait_resp(c0);
    chk("ff_ok", 32'(resp_ok_q), 32'd1);
    chk("ff_code", 32'(resp_code_q), 32'h00);
    tick();
    rx_byte(8'hAA, 1'b1);
`endif
    chk("ff_tx_count", 32'(tx_seen.size()), 32'd1);
    repeat (3) tick();

    // Reset while waiting for the ACK abandons the command silently.
    c0 = resp_cnt;
    issue(8'hF3, 1'b0, 8'h00);
    wait_hs_or_resp(r);
    u_if.tx_done = 1'b1; tick(); u_if.tx_done = 1'b0;
    repeat (3) tick();
    chk("busy_in_wait_ack", 32'(u_if.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(u_if.busy), 32'd0);
    chk("arst_tx_valid", 32'(u_if.tx_valid), 32'd0);
    chk("arst_cmd_ready", 32'(u_if.cmd_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_no_resp", 32'(resp_cnt - c0), 32'd0);

    // Reset while a byte is being offered drops tx_valid at once.
    issue(8'hF2, 1'b0, 8'h00);
    tick();
    chk("send_tx_valid", 32'(u_if.tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_send_tx_valid", 32'(u_if.tx_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_send_no_resp", 32'(resp_cnt - c0), 32'd0);
    oc = '{OC_ACK, OC_ACK, 0, 0, 0, 0, 0, 0};
    run_cmd(8'hED, 1'b1, 8'h05);

    // Randomized commands and device behaviour.
    for (int n = 0; n < 30; n++) begin
      int w;
      for (int j = 0; j < 8; j++) begin
        w = $urandom_range(0, 99);
        oc[j] = (w < 60) ? OC_ACK : (w < 75) ? OC_NAK : (w < 90) ? OC_ERR : OC_SIL;
      end
      run_cmd(8'($urandom_range(0, 254)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) rx_byte(8'($urandom_range(0, 255)), 1'b1);
    end

    repeat (5) tick();
    chk("scan_queue_empty", 32'(scan_exp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
